// File: rtl/arbitrated_single_port_ram.sv
// arbitrated_single_port_ram
//   Single-port RAM fronted by a one-access-per-cycle arbiter serving
//   independent write and read valid/ready request ports. Writes win ties
//   until MAX_WRITE_BURST consecutive write grants have been given while a
//   read waits, then the read is granted.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-high reset
//   writeValid     write request present
//   writeReady     write granted this cycle (combinational)
//   writeAddr      write word address
//   writeData      write data
//   writeMask      lane i enables bits [i*STROBE_WIDTH +: STROBE_WIDTH]
//   readValid      read request present
//   readReady      read granted this cycle (combinational)
//   readAddr       read word address
//   readDataValid  one-cycle pulse, readData holds a granted read result
//   readData       read result, held until the next read completes
//
// Build option
//   RAM_OUTPUT_REG_EN  adds an output register after the array
//                      (read latency 2 instead of 1).
module arbitrated_single_port_ram #(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH      = 14,
  parameter int unsigned STROBE_WIDTH    = 4,
  parameter int unsigned MAX_WRITE_BURST = 4,
  localparam int unsigned MASK_WIDTH     = DATA_WIDTH / STROBE_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  writeValid,
  output logic                  writeReady,
  input  logic [ADDR_WIDTH-1:0] writeAddr,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic [MASK_WIDTH-1:0] writeMask,
  input  logic                  readValid,
  output logic                  readReady,
  input  logic [ADDR_WIDTH-1:0] readAddr,
  output logic                  readDataValid,
  output logic [DATA_WIDTH-1:0] readData
);

  localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
  localparam int unsigned STREAK_W = 8;
  localparam logic [STREAK_W-1:0] BURST_MAX = STREAK_W'(MAX_WRITE_BURST);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [STREAK_W-1:0]   write_streak;
  logic [STREAK_W-1:0]   write_streak_nxt;

  // Arbiter: write priority, yielding to a waiting read once the burst is spent.
  always_comb begin
    writeReady = 1'b0;
    readReady  = 1'b0;
    if (!reset) begin
      if (writeValid && (!readValid || (write_streak < BURST_MAX))) begin
        writeReady = 1'b1;
      end else if (readValid) begin
        readReady = 1'b1;
      end
    end
  end

  // Streak only counts writes that a pending read had to wait behind.
  always_comb begin
    write_streak_nxt = write_streak;
    if (readReady || !readValid) begin
      write_streak_nxt = '0;
    end else if (writeReady) begin
      write_streak_nxt = write_streak + STREAK_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_streak <= '0;
    end else begin
      write_streak <= write_streak_nxt;
    end
  end

  // Masked write; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (writeReady) begin
      for (int i = 0; i < int'(MASK_WIDTH); i++) begin
        if (writeMask[i]) begin
          mem[writeAddr][i*STROBE_WIDTH +: STROBE_WIDTH] <= writeData[i*STROBE_WIDTH +: STROBE_WIDTH];
        end
      end
    end
  end

`ifdef RAM_OUTPUT_REG_EN
  logic [DATA_WIDTH-1:0] array_q;
  logic                  array_v_q;

  // Array output stage followed by the extra output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      array_q       <= '0;
      array_v_q     <= 1'b0;
      readData      <= '0;
      readDataValid <= 1'b0;
    end else begin
      array_v_q     <= readReady;
      if (readReady) begin
        array_q <= mem[readAddr];
      end
      readDataValid <= array_v_q;
      if (array_v_q) begin
        readData <= array_q;
      end
    end
  end
`else
  // Read result registered straight from the array.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readData      <= '0;
      readDataValid <= 1'b0;
    end else begin
      readDataValid <= readReady;
      if (readReady) begin
        readData <= mem[readAddr];
      end
    end
  end
`endif

endmodule

// File: doc/arbitrated_single_port_ram.md
Name: arbitrated_single_port_ram

Overview:
- Parametrised single-port RAM with independent write and read request ports, each using a valid/ready handshake.
- A one-access-per-cycle arbiter sits in front of one single-port array.
- Write has priority, bounded by a starvation counter that guarantees forward progress for reads.
- Replaces fixed 16-bit / 16k-entry RAM wrappers in texture and framebuffer paths, where callers previously had to avoid simultaneous read and write.

Parameters:
- DATA_WIDTH, 16, data bits per word; must be a multiple of STROBE_WIDTH.
- ADDR_WIDTH, 14, word address bits; depth = 2^ADDR_WIDTH.
- STROBE_WIDTH, 4, bits per write-mask lane; MASK_WIDTH = DATA_WIDTH/STROBE_WIDTH.
- MAX_WRITE_BURST, 4, maximum consecutive write grants while a read is pending; legal range 1..255.

Ports:
- clk, in, 1, single clock; all logic on its rising edge.
- reset, in, 1, asynchronous, active-high reset.
- writeValid, in, 1, write request present.
- writeReady, out, 1, write granted this cycle.
- writeAddr, in, ADDR_WIDTH, write word address.
- writeData, in, DATA_WIDTH, write data.
- writeMask, in, MASK_WIDTH, lane i enables bits [i*STROBE_WIDTH +: STROBE_WIDTH].
- readValid, in, 1, read request present.
- readReady, out, 1, read granted this cycle.
- readAddr, in, ADDR_WIDTH, read word address.
- readDataValid, out, 1, one-cycle pulse; readData holds the result of a granted read.
- readData, out, DATA_WIDTH, read result; holds its value until the next read completes.

Behaviour:
- Handshake:
  - Transfer occurs when valid && ready.
  - A requester holds valid, address, data and mask stable until accepted.
  - Ready is combinational from both valids and streak state. It never depends on its own port's address or data.
- Arbitration, at most one array access per cycle:
  - Only writeValid: grant write.
  - Only readValid: grant read.
  - Both: grant write if writeStreak < MAX_WRITE_BURST, else grant read.
  - Neither: no access; array chip-select deasserted.
- writeStreak counter, 8 bit:
  - +1 on a write grant while readValid = 1.
  - Cleared on any read grant, or in any cycle with readValid = 0.
  - Never exceeds MAX_WRITE_BURST.
- Write:
  - Masked lanes update at the granting clock edge.
  - Unmasked lanes keep their old value.
  - A mask of all zeros still consumes the grant and changes nothing.
- Read:
  - Array read at the granting edge.
  - readData and readDataValid = 1 appear in the next cycle (latency 1).
  - Back-to-back reads give one result per cycle.
- Ordering:
  - Accesses complete in grant order.
  - A read granted after a write to the same address returns the new data.
  - A read and a write are never granted in the same cycle.
- Address wrap: none. Full ADDR_WIDTH is decoded, and every address is valid.
- Reset:
  - readDataValid = 0, readData = 0, writeStreak = 0.
  - writeReady and readReady follow from the valids once reset is released; both are 0 while reset = 1.
  - Array contents are not reset.
  - Reset mid-operation drops any in-flight readDataValid pulse. A write granted at the same edge that reset asserts is not guaranteed.

Optional Feature:
- Macro RAM_OUTPUT_REG_EN.
- Defined:
  - Extra register stage after the array.
  - Read latency = 2; readDataValid is delayed with the data.
  - Back-to-back reads remain one per cycle.
  - The register resets to 0, and an in-flight result is dropped on reset.
- Undefined: read latency = 1 as specified above.
- Arbitration and write timing are identical in both builds.

Test Plan:
- Basic write then read:
  - Write 0x1234 to addr 0x0005 with mask 0xF, then read 0x0005.
  - Expect readDataValid one cycle after the read grant and readData = 0x1234.
- Masked write:
  - Write 0xFFFF to addr 0x10 with mask 0xF, then write 0x0000 with mask 0x5.
  - A read returns 0xF0F0.
- Starvation bound:
  - Hold writeValid and readValid high, MAX_WRITE_BURST = 4.
  - Expect grants W,W,W,W,R,W,W,W,W,R.
  - readDataValid follows each R grant by 1 cycle.
- Simultaneous same address:
  - Addr 0x20 holds 0xAAAA; in one cycle request write 0x5555 and read 0x20.
  - Write is granted first; the later read returns 0x5555, never both granted in one cycle.
- Reset mid-read:
  - Assert reset asynchronously in the cycle after a read grant.
  - readDataValid = 0 and readData = 0 immediately; no pulse after release.
  - Earlier array data is still readable.
- Build with RAM_OUTPUT_REG_EN:
  - Reads of addrs 1, 2, 3 on consecutive cycles.
  - Results appear on consecutive cycles, each 2 cycles after its grant.
